// File: rtl/cp0_pkg.sv
// CP0 register numbers, ExcCode values, Status/Cause field positions and the
// exception priority encoder shared by cp0_ctrl and its testbench-facing logic.
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;
    localparam logic [4:0] CP0_CONFIG   = 5'd16;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LSB = 8;
    localparam int STATUS_CU0    = 28;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_IP_LSB  = 8;
    localparam int CAUSE_BD      = 31;

    // exc_i bits that carry a faulting address (AdEL-fetch, AdEL-data, AdES)
    localparam logic [7:0] EXC_BADV_MASK = 8'b1100_0010;

    function automatic logic [4:0] exc_code_f(input logic [7:0] exc);
        logic [4:0] code;
        if (exc[0])      code = EXC_INT;
        else if (exc[1]) code = EXC_ADEL;
        else if (exc[2]) code = EXC_RI;
        else if (exc[3]) code = EXC_OV;
        else if (exc[4]) code = EXC_SYS;
        else if (exc[5]) code = EXC_BP;
        else if (exc[6]) code = EXC_ADEL;
        else if (exc[7]) code = EXC_ADES;
        else             code = EXC_INT;
        return code;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer with the sticky Cause.IP[7] latch.
// Build option CP0_COUNT_HALF_RATE_EN makes Count advance every second cycle.
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_irq_o
);

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_irq;
    logic        w_inc;
    logic        w_match;

`ifdef CP0_COUNT_HALF_RATE_EN
    logic r_tog;

    // Divide-by-two enable; restarting it on a Count write keeps the write-to-tick spacing fixed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tog <= 1'b0;
        end else if (count_we_i) begin
            r_tog <= 1'b0;
        end else begin
            r_tog <= ~r_tog;
        end
    end

    assign w_inc = r_tog;
`else
    assign w_inc = 1'b1;
`endif

    assign w_match = (r_count == r_compare) && (r_compare != 32'd0);

    // Count/Compare registers and the interrupt latch cleared only by a Compare write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count   <= 32'd0;
            r_compare <= 32'd0;
            r_irq     <= 1'b0;
        end else begin
            if (count_we_i) begin
                r_count <= wdata_i;
            end else if (w_inc) begin
                r_count <= r_count + 32'd1;
            end else begin
                r_count <= r_count;
            end

            if (compare_we_i) begin
                r_compare <= wdata_i;
                r_irq     <= 1'b0;
            end else if (w_match) begin
                r_irq     <= 1'b1;
            end else begin
                r_irq     <= r_irq;
            end
        end
    end

    assign count_o     = r_count;
    assign compare_o   = r_compare;
    assign timer_irq_o = r_irq;

endmodule

// File: rtl/cp0_ctrl.sv
// CP0 system-control block: exception priority, Status/Cause/EPC/BadVAddr state,
// ERET handling, read mux. Optional build macro: CP0_COUNT_HALF_RATE_EN (in cp0_timer).
module cp0_ctrl
    import cp0_pkg::*;
#(
    parameter int          DATA_W     = 32,
    parameter int          NUM_HW_INT = 6,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
    parameter logic [31:0] PRID_VAL   = 32'h004C_0102,
    parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [4:0]            waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [4:0]            raddr_i,
    output logic [DATA_W-1:0]     rdata_o,
    input  logic [NUM_HW_INT-1:0] int_i,
    input  logic [7:0]            exc_i,
    input  logic                  eret_i,
    input  logic [DATA_W-1:0]     pc_i,
    input  logic                  in_ds_i,
    input  logic [DATA_W-1:0]     badvaddr_i,
    output logic [DATA_W-1:0]     status_o,
    output logic [DATA_W-1:0]     cause_o,
    output logic [DATA_W-1:0]     epc_o,
    output logic                  int_pend_o,
    output logic                  flush_o,
    output logic [DATA_W-1:0]     new_pc_o
);

    logic                  w_exc_taken;
    logic                  w_eret_taken;
    logic [7:0]            w_exc_sel;
    logic [4:0]            w_exc_code;
    logic                  w_bad_load;
    logic                  w_wr_count;
    logic                  w_wr_compare;
    logic                  w_wr_status;
    logic                  w_wr_cause;
    logic                  w_wr_epc;
    logic [31:0]           w_count;
    logic [31:0]           w_compare;
    logic                  w_timer_irq;
    logic [7:0]            w_ip;
    logic [31:0]           w_status;
    logic [31:0]           w_cause;

    logic [7:0]            r_status_im;
    logic                  r_status_exl;
    logic                  r_status_ie;
    logic                  r_cause_bd;
    logic [4:0]            r_cause_exc;
    logic [1:0]            r_cause_ip_sw;
    logic [NUM_HW_INT-1:0] r_cause_ip_hw;
    logic [DATA_W-1:0]     r_epc;
    logic [DATA_W-1:0]     r_badvaddr;

    assign w_exc_taken  = |exc_i;
    assign w_eret_taken = eret_i & ~w_exc_taken;
    // Isolate the lowest set bit: that is the highest-priority source
    assign w_exc_sel    = exc_i & (8'd0 - exc_i);
    assign w_exc_code   = exc_code_f(exc_i);
    assign w_bad_load   = |(w_exc_sel & EXC_BADV_MASK);

    assign w_wr_count   = we_i && (waddr_i == CP0_COUNT);
    assign w_wr_compare = we_i && (waddr_i == CP0_COMPARE);
    assign w_wr_status  = we_i && (waddr_i == CP0_STATUS);
    assign w_wr_cause   = we_i && (waddr_i == CP0_CAUSE);
    assign w_wr_epc     = we_i && (waddr_i == CP0_EPC);

    cp0_timer u_timer (
        .clk          (clk),
        .rst          (rst),
        .count_we_i   (w_wr_count),
        .compare_we_i (w_wr_compare),
        .wdata_i      (wdata_i[31:0]),
        .count_o      (w_count),
        .compare_o    (w_compare),
        .timer_irq_o  (w_timer_irq)
    );

    // Status/Cause state: exception beats ERET beats MTC0 on EXL; exception owns ExcCode/BD
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_status_im   <= 8'h00;
            r_status_exl  <= 1'b0;
            r_status_ie   <= 1'b0;
            r_cause_bd    <= 1'b0;
            r_cause_exc   <= 5'd0;
            r_cause_ip_sw <= 2'b00;
            r_cause_ip_hw <= {NUM_HW_INT{1'b0}};
        end else begin
            r_cause_ip_hw <= int_i;

            if (w_wr_status) begin
                r_status_im <= wdata_i[STATUS_IM_LSB +: 8];
                r_status_ie <= wdata_i[STATUS_IE];
            end else begin
                r_status_im <= r_status_im;
                r_status_ie <= r_status_ie;
            end

            if (w_exc_taken) begin
                r_status_exl <= 1'b1;
            end else if (w_eret_taken) begin
                r_status_exl <= 1'b0;
            end else if (w_wr_status) begin
                r_status_exl <= wdata_i[STATUS_EXL];
            end else begin
                r_status_exl <= r_status_exl;
            end

            if (w_wr_cause) begin
                r_cause_ip_sw <= wdata_i[CAUSE_IP_LSB +: 2];
            end else begin
                r_cause_ip_sw <= r_cause_ip_sw;
            end

            if (w_exc_taken) begin
                r_cause_exc <= w_exc_code;
                r_cause_bd  <= r_status_exl ? r_cause_bd : in_ds_i;
            end else begin
                r_cause_exc <= r_cause_exc;
                r_cause_bd  <= r_cause_bd;
            end
        end
    end

    // EPC is frozen by a nested exception; BadVAddr loads only for address errors
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_epc      <= {DATA_W{1'b0}};
            r_badvaddr <= {DATA_W{1'b0}};
        end else begin
            if (w_exc_taken) begin
                if (!r_status_exl) begin
                    r_epc <= in_ds_i ? (pc_i - DATA_W'(32'd4)) : pc_i;
                end else begin
                    r_epc <= r_epc;
                end
            end else if (w_wr_epc) begin
                r_epc <= wdata_i;
            end else begin
                r_epc <= r_epc;
            end

            if (w_exc_taken && w_bad_load) begin
                r_badvaddr <= badvaddr_i;
            end else begin
                r_badvaddr <= r_badvaddr;
            end
        end
    end

    // Architectural Status/Cause words; IP[7] is shared by the timer and the top hardware line
    always_comb begin
        w_ip                        = 8'h00;
        w_ip[1:0]                   = r_cause_ip_sw;
        w_ip[2 +: NUM_HW_INT]       = r_cause_ip_hw;
        w_ip[7]                     = w_ip[7] | w_timer_irq;

        w_status                    = 32'h0000_0000;
        w_status[STATUS_CU0]        = 1'b1;
        w_status[STATUS_IM_LSB +: 8] = r_status_im;
        w_status[STATUS_EXL]        = r_status_exl;
        w_status[STATUS_IE]         = r_status_ie;

        w_cause                     = 32'h0000_0000;
        w_cause[CAUSE_BD]           = r_cause_bd;
        w_cause[CAUSE_IP_LSB +: 8]  = w_ip;
        w_cause[CAUSE_EXC_LSB +: 5] = r_cause_exc;
    end

    // Redirect target: vector on exception, EPC (with same-cycle MTC0 bypass) on ERET
    always_comb begin
        new_pc_o = {DATA_W{1'b0}};
        if (w_exc_taken) begin
            new_pc_o = DATA_W'(EXC_VECTOR);
        end else if (w_eret_taken) begin
            new_pc_o = w_wr_epc ? wdata_i : r_epc;
        end else begin
            new_pc_o = {DATA_W{1'b0}};
        end
    end

    // Read mux shows pre-edge register contents
    always_comb begin
        rdata_o = {DATA_W{1'b0}};
        case (raddr_i)
            CP0_BADVADDR: rdata_o = r_badvaddr;
            CP0_COUNT:    rdata_o = DATA_W'(w_count);
            CP0_COMPARE:  rdata_o = DATA_W'(w_compare);
            CP0_STATUS:   rdata_o = DATA_W'(w_status);
            CP0_CAUSE:    rdata_o = DATA_W'(w_cause);
            CP0_EPC:      rdata_o = r_epc;
            CP0_PRID:     rdata_o = DATA_W'(PRID_VAL);
            CP0_CONFIG:   rdata_o = DATA_W'(CONFIG_VAL);
            default:      rdata_o = {DATA_W{1'b0}};
        endcase
    end

    assign status_o   = DATA_W'(w_status);
    assign cause_o    = DATA_W'(w_cause);
    assign epc_o      = r_epc;
    assign flush_o    = w_exc_taken | w_eret_taken;
    assign int_pend_o = r_status_ie & ~r_status_exl & (|(w_ip & r_status_im));

endmodule
